// File: rtl/dcache_unit.sv
// Data-side memory unit: direct-mapped, write-through, no-write-allocate
// word cache in front of a byte-wide RAM port. Serves one load or store
// at a time. Addresses with addr[17:16]==2'b11 are IO and bypass the cache.
module dcache_unit #(
  parameter int CACHE_WIDTH = 4,
  parameter int CACHE_SIZE  = 2**CACHE_WIDTH,
  parameter int TAG_WIDTH   = 16 - CACHE_WIDTH
) (
  input  logic        clockIn,
  input  logic        resetIn,
  input  logic [1:0]  accessType,
  input  logic        readWriteIn,
  input  logic [31:0] dataAddr,
  input  logic [31:0] dataIn,
  output logic        dataValid,
  output logic [31:0] dataOut,
  output logic        dataWriteSuc,
  output logic        busy,
  input  logic [7:0]  memDataIn,
  output logic [7:0]  memDataOut,
  output logic [31:0] memAddrOut,
  output logic        memWriteOut,
  input  logic        ioBufferFull
);

  typedef enum logic [1:0] {IDLE, FETCH, STORE, RESPOND} state_t;

  state_t state, state_next;

  // Cache storage: data and tags carry no reset, only the valid bits do.
  logic [31:0]          line_data [CACHE_SIZE];
  logic [TAG_WIDTH-1:0] line_tag  [CACHE_SIZE];
  logic [CACHE_SIZE-1:0] line_valid;

  // Latched request.
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic        req_io;
  logic        req_hit;

  // Byte counter shared by FETCH and STORE, plus the fetch assembly buffer.
  logic [2:0]  cnt;
  logic [31:0] fetch_buf;

  logic [CACHE_WIDTH-1:0] in_idx, req_idx;
  logic [TAG_WIDTH-1:0]   in_tag, req_tag;
  logic        in_io, in_hit;
  logic [2:0]  req_len, fetch_len, cnt_inc;
  logic [1:0]  cap_sel, st_off;
  logic [31:0] fetch_base, fetch_word;
  logic        fetch_done, store_fire;

  // Number of bytes for an access size code.
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      2'b01:   return 3'd1;
      2'b10:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Pull n bytes starting at byte offset off out of a word, zero-extended.
  function automatic logic [31:0] extract(input logic [31:0] w,
                                          input logic [1:0]  off,
                                          input logic [1:0]  sz);
    logic [31:0] s;
    s = w >> {off, 3'b000};
    case (sz)
      2'b01:   return {24'd0, s[7:0]};
      2'b10:   return {16'd0, s[15:0]};
      default: return s;
    endcase
  endfunction

  // Little-endian byte k of a word.
  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] k);
    return w[{k, 3'b000} +: 8];
  endfunction

  assign in_idx     = dataAddr[CACHE_WIDTH+1:2];
  assign in_tag     = dataAddr[17:2+CACHE_WIDTH];
  assign in_io      = (dataAddr[17:16] == 2'b11);
  assign in_hit     = !in_io && line_valid[in_idx] && (line_tag[in_idx] == in_tag);
  assign req_idx    = req_addr[CACHE_WIDTH+1:2];
  assign req_tag    = req_addr[17:2+CACHE_WIDTH];
  assign req_len    = size_bytes(req_size);
  // IO loads read exactly n bytes from the address; cached loads fill a whole line.
  assign fetch_len  = req_io ? req_len : 3'd4;
  assign fetch_base = req_io ? req_addr : {req_addr[31:2], 2'b00};
  assign cnt_inc    = cnt + 3'd1;
  // RAM data lags the address by one cycle, so byte cnt-1 arrives while cnt is current.
  assign cap_sel    = cnt[1:0] - 2'd1;
  assign st_off     = req_addr[1:0] + cnt[1:0];
  assign fetch_done = (state == FETCH) && (cnt == fetch_len);

  // Assembled fetch word including the byte arriving this cycle.
  always_comb begin
    fetch_word = fetch_buf;
    if (cnt != 3'd0) fetch_word[{cap_sel, 3'b000} +: 8] = memDataIn;
  end

  // State register.
  always_ff @(posedge clockIn) begin
    if (resetIn) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state logic and the combinational RAM write strobe / busy flag.
  always_comb begin
    state_next  = state;
    store_fire  = 1'b0;
    memWriteOut = 1'b0;
    busy        = (state != IDLE);
    case (state)
      IDLE: begin
        if (accessType != 2'b00) begin
          if (!readWriteIn)  state_next = STORE;
          else if (!in_hit)  state_next = FETCH;
        end
      end
      FETCH: begin
        if (fetch_done) state_next = RESPOND;
      end
      STORE: begin
        // IO writes wait for room in the output buffer; the byte index holds.
        store_fire  = !(req_io && ioBufferFull);
        memWriteOut = store_fire;
        if (store_fire && (cnt == req_len - 3'd1)) state_next = RESPOND;
      end
      RESPOND: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Control and output registers: pulses, RAM address/data, counter, valid bits.
  always_ff @(posedge clockIn) begin
    if (resetIn) begin
      dataValid    <= 1'b0;
      dataWriteSuc <= 1'b0;
      dataOut      <= '0;
      memAddrOut   <= '0;
      memDataOut   <= '0;
      cnt          <= '0;
      line_valid   <= '0;
    end else begin
      dataValid    <= 1'b0;
      dataWriteSuc <= 1'b0;
      case (state)
        IDLE: begin
          if (accessType != 2'b00) begin
            cnt <= '0;
            if (readWriteIn) begin
              if (in_hit) begin
                dataValid <= 1'b1;
                dataOut   <= extract(line_data[in_idx], dataAddr[1:0], accessType);
              end else begin
                memAddrOut <= in_io ? dataAddr : {dataAddr[31:2], 2'b00};
              end
            end else begin
              memAddrOut <= dataAddr;
              memDataOut <= dataIn[7:0];
            end
          end
        end
        FETCH: begin
          cnt <= cnt_inc;
          if (cnt_inc < fetch_len) memAddrOut <= fetch_base + {29'd0, cnt_inc};
          if (fetch_done) begin
            dataValid <= 1'b1;
            dataOut   <= extract(fetch_word, req_io ? 2'b00 : req_addr[1:0], req_size);
            if (!req_io) line_valid[req_idx] <= 1'b1;
          end
        end
        STORE: begin
          if (store_fire) begin
            cnt <= cnt_inc;
            if (cnt == req_len - 3'd1) begin
              dataWriteSuc <= 1'b1;
            end else begin
              memAddrOut <= req_addr + {29'd0, cnt_inc};
              memDataOut <= byte_sel(req_data, cnt_inc[1:0]);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Request latch, fetch buffer, and line data/tag updates (fill and write-through hit).
  always_ff @(posedge clockIn) begin
    case (state)
      IDLE: begin
        if (accessType != 2'b00) begin
          req_size <= accessType;
          req_addr <= dataAddr;
          req_data <= dataIn;
          req_io   <= in_io;
          req_hit  <= in_hit;
        end
      end
      FETCH: begin
        if (cnt != 3'd0) fetch_buf[{cap_sel, 3'b000} +: 8] <= memDataIn;
        if (fetch_done && !req_io) begin
          line_data[req_idx] <= fetch_word;
          line_tag[req_idx]  <= req_tag;
        end
      end
      STORE: begin
        if (store_fire && req_hit) line_data[req_idx][{st_off, 3'b000} +: 8] <= memDataOut;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dcache_unit.sv
// Scoreboard bench for dcache_unit: stimulus pushes expected responses,
// RAM writes and fetch addresses into queues; a negedge monitor pops and compares.
module tb_dcache_unit;

  logic        clk = 1'b0;
  logic        resetIn = 1'b1;
  logic [1:0]  accessType = 2'b00;
  logic        readWriteIn = 1'b0;
  logic [31:0] dataAddr = '0;
  logic [31:0] dataIn = '0;
  logic        dataValid;
  logic [31:0] dataOut;
  logic        dataWriteSuc;
  logic        busy;
  logic [7:0]  memDataIn;
  logic [7:0]  memDataOut;
  logic [31:0] memAddrOut;
  logic        memWriteOut;
  logic        ioBufferFull = 1'b0;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct { logic is_load; logic [31:0] data; int due; } resp_t;
  typedef struct { logic [31:0] addr; logic [7:0] data; int due; } wr_t;
  typedef struct { logic [31:0] addr; int due; } ad_t;

  resp_t rq[$];
  wr_t   wq[$];
  ad_t   aq[$];

  bit [7:0] ram [262144];
  bit       ram_loaded = 1'b0;

  dcache_unit dut (
    .clockIn      (clk),
    .resetIn      (resetIn),
    .accessType   (accessType),
    .readWriteIn  (readWriteIn),
    .dataAddr     (dataAddr),
    .dataIn       (dataIn),
    .dataValid    (dataValid),
    .dataOut      (dataOut),
    .dataWriteSuc (dataWriteSuc),
    .busy         (busy),
    .memDataIn    (memDataIn),
    .memDataOut   (memDataOut),
    .memAddrOut   (memAddrOut),
    .memWriteOut  (memWriteOut),
    .ioBufferFull (ioBufferFull)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: read data one cycle after the address, writes on memWriteOut.
  always @(posedge clk) begin
    if (!ram_loaded) begin
      ram[18'h00100] <= 8'h11; ram[18'h00101] <= 8'h22;
      ram[18'h00102] <= 8'h33; ram[18'h00103] <= 8'h44;
      ram[18'h00200] <= 8'hA1; ram[18'h00201] <= 8'hB2;
      ram[18'h00202] <= 8'hC3; ram[18'h00203] <= 8'hD4;
      ram[18'h30004] <= 8'h5A;
      ram_loaded <= 1'b1;
    end else if (memWriteOut) begin
      ram[memAddrOut[17:0]] <= memDataOut;
    end
    memDataIn <= ram[memAddrOut[17:0]];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: compare every pulse, write and scheduled fetch address.
  always @(negedge clk) begin
    resp_t e;
    wr_t   w;
    ad_t   a;
    if (dataValid && dataWriteSuc) chk("pulse_overlap", 32'(dataWriteSuc), 32'd0);
    if (dataValid || dataWriteSuc) begin
      if (rq.size() == 0) begin
        chk("unexpected_pulse", {dataOut[31:1], dataValid}, 32'hFFFF_FFFF);
      end else begin
        e = rq.pop_front();
        chk("resp_kind", 32'(dataValid), 32'(e.is_load));
        if (e.is_load) chk("load_data", dataOut, e.data);
        chk("resp_cycle", 32'(cyc), 32'(e.due));
      end
    end else if (rq.size() != 0 && cyc > rq[0].due) begin
      e = rq.pop_front();
      chk("missing_pulse_due", 32'(cyc), 32'(e.due));
    end

    if (memWriteOut) begin
      if (wq.size() == 0) begin
        chk("unexpected_write_addr", memAddrOut, 32'hFFFF_FFFF);
      end else begin
        w = wq.pop_front();
        chk("write_addr", memAddrOut, w.addr);
        chk("write_data", 32'(memDataOut), 32'(w.data));
        chk("write_cycle", 32'(cyc), 32'(w.due));
      end
    end else if (wq.size() != 0 && cyc > wq[0].due) begin
      w = wq.pop_front();
      chk("missing_write_due", 32'(cyc), 32'(w.due));
    end

    if (aq.size() != 0 && cyc >= aq[0].due) begin
      a = aq.pop_front();
      chk("fetch_addr", memAddrOut, a.addr);
      chk("fetch_no_write", 32'(memWriteOut), 32'd0);
    end
  end

  // Issue one request and wait for its response pulse (bounded).
  task automatic issue(input logic [1:0] ty, input logic rd, input logic [31:0] addr,
                       input logic [31:0] din, input logic [31:0] exp, input int lat,
                       input int stall);
    int i, n, na;
    logic io;
    logic [31:0] base, sh;
    n  = (ty == 2'b01) ? 1 : (ty == 2'b10) ? 2 : 4;
    io = (addr[17:16] == 2'b11);
    @(posedge clk); #1;
    i = cyc;
    accessType   = ty;
    readWriteIn  = rd;
    dataAddr     = addr;
    dataIn       = din;
    ioBufferFull = (stall > 0);
    rq.push_back('{is_load: rd, data: exp, due: i + lat});
    if (!rd) begin
      for (int k = 0; k < n; k++) begin
        sh = din >> (8 * k);
        wq.push_back('{addr: addr + 32'(k), data: sh[7:0], due: i + 1 + stall + k});
      end
    end else if (lat > 1) begin
      na   = io ? n : 4;
      base = io ? addr : {addr[31:2], 2'b00};
      for (int k = 0; k < na; k++) aq.push_back('{addr: base + 32'(k), due: i + 1 + k});
    end
    @(posedge clk); #1;
    accessType = 2'b00;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
    end
    ioBufferFull = 1'b0;
    for (int wcnt = 0; wcnt < 40 && rq.size() != 0; wcnt++) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_dataValid",    32'(dataValid),    32'd0);
    chk("reset_dataWriteSuc", 32'(dataWriteSuc), 32'd0);
    chk("reset_dataOut",      dataOut,           32'd0);
    chk("reset_memAddrOut",   memAddrOut,        32'd0);
    chk("reset_memWriteOut",  32'(memWriteOut),  32'd0);
    chk("reset_memDataOut",   32'(memDataOut),   32'd0);
    chk("reset_busy",         32'(busy),         32'd0);
    resetIn = 1'b0;

    // Word miss then hit; sub-word hits.
    issue(2'b11, 1'b1, 32'h0000_0100, 32'h0, 32'h4433_2211, 6, 0);
    issue(2'b11, 1'b1, 32'h0000_0100, 32'h0, 32'h4433_2211, 1, 0);
    issue(2'b01, 1'b1, 32'h0000_0102, 32'h0, 32'h0000_0033, 1, 0);
    issue(2'b10, 1'b1, 32'h0000_0102, 32'h0, 32'h0000_4433, 1, 0);
    // Half store to a resident line, then hit sees the update.
    issue(2'b10, 1'b0, 32'h0000_0100, 32'h0000_BEEF, 32'h0, 3, 0);
    issue(2'b11, 1'b1, 32'h0000_0100, 32'h0, 32'h4433_BEEF, 1, 0);
    // IO byte store stalled three cycles; same index line untouched.
    issue(2'b01, 1'b0, 32'h0003_0000, 32'h0000_0041, 32'h0, 5, 3);
    issue(2'b11, 1'b1, 32'h0000_0100, 32'h0, 32'h4433_BEEF, 1, 0);
    // IO loads are never cached.
    issue(2'b01, 1'b1, 32'h0003_0004, 32'h0, 32'h0000_005A, 3, 0);
    issue(2'b01, 1'b1, 32'h0003_0004, 32'h0, 32'h0000_005A, 3, 0);

    // Reset during a FETCH: no pulse, all lines invalidated.
    @(posedge clk); #1;
    accessType = 2'b11; readWriteIn = 1'b1; dataAddr = 32'h0000_0200;
    @(posedge clk); #1;
    accessType = 2'b00;
    chk("fetch_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    resetIn = 1'b1;
    @(posedge clk); #1;
    resetIn = 1'b0;
    chk("reset_mid_busy", 32'(busy), 32'd0);
    repeat (8) @(posedge clk);

    // Previously resident line misses; write-through data came from RAM.
    issue(2'b11, 1'b1, 32'h0000_0100, 32'h0, 32'h4433_BEEF, 6, 0);
    issue(2'b01, 1'b0, 32'h0000_0103, 32'h0000_0077, 32'h0, 2, 0);
    issue(2'b11, 1'b1, 32'h0000_0100, 32'h0, 32'h7733_BEEF, 1, 0);
    // Store miss to an aliasing index does not allocate.
    issue(2'b11, 1'b0, 32'h0000_0300, 32'hCAFE_F00D, 32'h0, 5, 0);
    issue(2'b11, 1'b1, 32'h0000_0100, 32'h0, 32'h7733_BEEF, 1, 0);
    // Abandoned address takes the full fetch latency.
    issue(2'b11, 1'b1, 32'h0000_0200, 32'h0, 32'hD4C3_B2A1, 6, 0);
    issue(2'b10, 1'b1, 32'h0000_0202, 32'h0, 32'h0000_D4C3, 1, 0);
    issue(2'b11, 1'b1, 32'h0000_0300, 32'h0, 32'hCAFE_F00D, 6, 0);

    repeat (10) @(posedge clk);
    #1;
    chk("queues_drained", 32'(rq.size() + wq.size() + aq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
